coeff_load_sequencer: RTL and testbench
=======================================

// Module: coeff_load_sequencer
// PURPOSE
//  Buffers NUM_COEFF FIR coefficients written by the host and replays them into the FIR
//  controller's load-coefficient handshake (lc/modwait). Arbitrates the shared datapath:
//  gates sample data_ready while a load runs; defers a load until a running sample completes.
//  Sits between the host register interface and the FIR controller/datapath.
// PARAMETERS
//  DATA_W     16  coefficient width
//  NUM_COEFF  4   coefficients per set (index width IDX_W = $clog2(NUM_COEFF))
//  TIMEOUT    16  max cycles waiting for one modwait edge before abort
// PORTS
//  clk             in   1       clock
//  n_rst           in   1       reset, asynchronous, active-low
//  coeff_wr        in   1       host write strobe into coefficient buffer
//  coeff_wr_idx    in   IDX_W   buffer slot written
//  coeff_wr_data   in   DATA_W  coefficient value
//  load_start      in   1       single-cycle request: load whole buffer into controller
//  data_ready_in   in   1       host sample-ready level
//  modwait         in   1       controller busy flag
//  lc              out  1       load-coefficient request to controller
//  fir_coefficient out  DATA_W  coefficient presented to datapath (registered)
//  data_ready_out  out  1       gated sample-ready to controller
//  busy            out  1       sequencer not in IDLE
//  load_done       out  1       1-cycle pulse, full set accepted
//  err             out  1       sticky timeout error; cleared by next load_start
//  wr_overrun      out  1       1-cycle pulse, host write dropped while busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, idx 0, buffer 0, pending_load 0.
//  Buffer: coeff_wr in IDLE or ERR writes slot next cycle; in any other state write dropped,
//   wr_overrun=1 next cycle. Buffer contents never altered by a load.
//  data_ready_out = data_ready_in & (state==IDLE); forced 0 in all other states.
//  busy = (state!=IDLE) & (state!=ERR).
//  FSM (registered state; lc, fir_coefficient, load_done registered):
//   IDLE:     load_start -> pending_load=1, err cleared. If pending_load & !data_ready_in &
//             !modwait -> ASSERT_LC, idx=0, fir_coefficient=buf[0]. A sample already in
//             flight (data_ready_in or modwait high) wins; load waits, pending kept.
//   ASSERT_LC: lc=1. modwait==1 seen -> WAIT_ACK (lc=0 next cycle).
//   WAIT_ACK: lc=0. modwait==0 seen -> idx==NUM_COEFF-1 ? DONE : NEXT.
//   NEXT:     idx+=1, fir_coefficient=buf[idx+1] -> ASSERT_LC. 1 cycle.
//   DONE:     load_done=1, pending_load=0 -> IDLE. 1 cycle.
//   ERR:      lc=0, err=1, pending_load=0; load_start -> IDLE path as above (retry from idx 0).
//  fir_coefficient held stable from entry of ASSERT_LC through WAIT_ACK (controller samples
//   it while modwait=1); changes only in NEXT or on entry to ASSERT_LC from IDLE.
//  lc never high two consecutive cycles after modwait rose; never high in WAIT_ACK.
//  Timeout: cycle counter cleared on each ASSERT_LC/WAIT_ACK entry, counts while in them;
//   reaching TIMEOUT -> ERR, lc=0 next cycle.
//  load_start while busy: ignored (no re-queue). load_start same cycle as coeff_wr in IDLE:
//   write completes first; load uses new value (load start is >=1 cycle later).
//  Async reset mid-load: immediate return to IDLE, lc=0, no load_done; buffer cleared.
//  Latency, quiet controller: load_start@T -> lc@T+2; per coefficient 1 ASSERT_LC cycle +
//   controller response + 1 WAIT_ACK + 1 NEXT.
// STRUCTURE
//  Package coeff_seq_pkg: state_t enum {IDLE,ASSERT_LC,WAIT_ACK,NEXT,DONE,ERR}, default
//   DATA_W/NUM_COEFF/TIMEOUT constants.
//  Sub-module: flex_counter (timeout counter; clear, count_enable, rollover_val=TIMEOUT,
//   rollover_flag -> timeout).
// TESTING
//  Write 0x0001,0x0002,0x0003,0x0004 to slots 0..3, load_start, model controller responds
//   modwait 1 cycle after lc -> fir_coefficient 1,2,3,4 seen while modwait=1, 4 lc pulses,
//   load_done once, busy low after.
//  data_ready_in high + modwait high, then load_start -> lc stays 0 until both low; then
//   load runs; data_ready_out=0 throughout load.
//  Controller never raises modwait -> err=1 after TIMEOUT+1 cycles, lc=0, busy=0;
//   next load_start clears err and completes the load.
//  coeff_wr during WAIT_ACK -> wr_overrun pulse, buffer slot unchanged (read back via reload).
//  n_rst low mid-load at idx 2 -> lc=0, load_done never pulses, outputs all 0.
//  load_start repeated while busy -> exactly one load_done, 4 lc pulses total.

Source files
------------

// File: rtl/coeff_seq_pkg.sv
// Shared types and default sizing for the FIR coefficient load sequencer.
package coeff_seq_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NUM_COEFF = 4;
    localparam int DEF_TIMEOUT   = 16;

    typedef enum logic [2:0] {
        IDLE,
        ASSERT_LC,
        WAIT_ACK,
        NEXT,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter; rollover_flag is high while the count equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count <= NUM_CNT_BITS'(1);
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/coeff_load_sequencer.sv
// Buffers a coefficient set from the host and replays it into the FIR controller's
// lc/modwait handshake, holding off sample traffic while a load owns the datapath.
module coeff_load_sequencer
    import coeff_seq_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_COEFF = DEF_NUM_COEFF,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    localparam int IDX_W    = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              coeff_wr,
    input  logic [IDX_W-1:0]  coeff_wr_idx,
    input  logic [DATA_W-1:0] coeff_wr_data,
    input  logic              load_start,
    input  logic              data_ready_in,
    input  logic              modwait,
    output logic              lc,
    output logic [DATA_W-1:0] fir_coefficient,
    output logic              data_ready_out,
    output logic              busy,
    output logic              load_done,
    output logic              err,
    output logic              wr_overrun
);

    localparam int                CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_COEFF - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_inc;
    logic [DATA_W-1:0] coeff_buf [NUM_COEFF];
    logic              pending_load;
    logic              host_owned;
    logic              timeout;
    logic              cnt_clear;
    logic              cnt_en;
    logic              lc_next;
    logic              load_done_next;

    assign idx_inc    = idx + 1'b1;
    assign host_owned = (state == IDLE) || (state == ERR);

    flex_counter #(
        .NUM_CNT_BITS(CNT_W)
    ) u_timeout_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (TIMEOUT_VAL),
        .rollover_flag(timeout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A sample already in flight (data_ready_in or modwait) keeps the load deferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pending_load && !data_ready_in && !modwait) begin
                    state_next = ASSERT_LC;
                end
            end
            ASSERT_LC: begin
                if (modwait) begin
                    state_next = WAIT_ACK;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            WAIT_ACK: begin
                if (!modwait) begin
                    state_next = (idx == LAST_IDX) ? DONE : NEXT;
                end else if (timeout) begin
                    state_next = ERR;
                end
            end
            NEXT:    state_next = ASSERT_LC;
            DONE:    state_next = IDLE;
            ERR: begin
                if (load_start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lc_next        = (state_next == ASSERT_LC);
        load_done_next = (state_next == DONE);
        cnt_en         = (state == ASSERT_LC) || (state == WAIT_ACK);
        cnt_clear      = (state_next != state) &&
                         ((state_next == ASSERT_LC) || (state_next == WAIT_ACK));
        busy           = (state != IDLE) && (state != ERR);
        data_ready_out = data_ready_in && (state == IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lc              <= 1'b0;
            load_done       <= 1'b0;
            fir_coefficient <= '0;
            idx             <= '0;
            pending_load    <= 1'b0;
            err             <= 1'b0;
            wr_overrun      <= 1'b0;
            coeff_buf       <= '{default: '0};
        end else begin
            lc         <= lc_next;
            load_done  <= load_done_next;
            wr_overrun <= coeff_wr && !host_owned;

            if (coeff_wr && host_owned) begin
                coeff_buf[coeff_wr_idx] <= coeff_wr_data;
            end

            if (load_start && host_owned) begin
                pending_load <= 1'b1;
            end else if ((state == DONE) || (state_next == ERR)) begin
                pending_load <= 1'b0;
            end

            if (load_start && host_owned) begin
                err <= 1'b0;
            end else if (state_next == ERR) begin
                err <= 1'b1;
            end

            // Coefficient only moves on load entry or in NEXT, so it is stable under modwait.
            if ((state == IDLE) && (state_next == ASSERT_LC)) begin
                idx             <= '0;
                fir_coefficient <= coeff_buf[0];
            end else if (state == NEXT) begin
                idx             <= idx_inc;
                fir_coefficient <= coeff_buf[idx_inc];
            end
        end
    end

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// Directed bench for coeff_load_sequencer with a simple FIR-controller handshake model.
module tb_coeff_load_sequencer;

    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          coeff_wr;
    logic [1:0]    coeff_wr_idx;
    logic [DW-1:0] coeff_wr_data;
    logic          load_start;
    logic          data_ready_in;
    logic          modwait;
    logic          lc;
    logic [DW-1:0] fir_coefficient;
    logic          data_ready_out;
    logic          busy;
    logic          load_done;
    logic          err;
    logic          wr_overrun;

    logic ctrl_auto;
    logic mw_man;
    logic mw_model;
    int   mw_hold;
    logic lc_q;
    int   lc_pulses;
    int   done_cnt;
    int   dr_viol;
    int   fir_unstable;
    logic [DW-1:0] got [$];

    int n_checks = 0;
    int n_pass   = 0;

    assign modwait = ctrl_auto ? mw_model : mw_man;

    always #5 clk = ~clk;

    coeff_load_sequencer #(
        .DATA_W   (DW),
        .NUM_COEFF(4),
        .TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .coeff_wr       (coeff_wr),
        .coeff_wr_idx   (coeff_wr_idx),
        .coeff_wr_data  (coeff_wr_data),
        .load_start     (load_start),
        .data_ready_in  (data_ready_in),
        .modwait        (modwait),
        .lc             (lc),
        .fir_coefficient(fir_coefficient),
        .data_ready_out (data_ready_out),
        .busy           (busy),
        .load_done      (load_done),
        .err            (err),
        .wr_overrun     (wr_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model and event monitor: modwait rises one cycle after lc, held 2 cycles.
    initial begin
        mw_model = 1'b0; mw_hold = 0; lc_q = 1'b0;
        lc_pulses = 0; done_cnt = 0; dr_viol = 0; fir_unstable = 0;
        forever begin
            @(posedge clk);
            #1;
            if (lc && !lc_q) lc_pulses++;
            lc_q = lc;
            if (load_done) done_cnt++;
            if (busy && data_ready_out) dr_viol++;
            if (!ctrl_auto) begin
                mw_hold  = 0;
                mw_model = 1'b0;
            end else if (mw_hold > 0) begin
                if (fir_coefficient != got[$]) fir_unstable++;
                mw_hold--;
                if (mw_hold == 0) mw_model = 1'b0;
            end else if (lc && !mw_model) begin
                mw_model = 1'b1;
                mw_hold  = 2;
                got.push_back(fir_coefficient);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input logic [1:0] i, input logic [DW-1:0] d);
        coeff_wr = 1'b1; coeff_wr_idx = i; coeff_wr_data = d;
        @(negedge clk);
        coeff_wr = 1'b0;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_lc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lc_pulses >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int base_lc, base_done, gb, hi;
        logic [DW-1:0] exp1 [4];
        logic [DW-1:0] exp4 [4];
        exp1 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        exp4 = '{16'h0001, 16'h0002, 16'h0003, 16'h00A5};

        n_rst = 1'b0; coeff_wr = 1'b0; coeff_wr_idx = '0; coeff_wr_data = '0;
        load_start = 1'b0; data_ready_in = 1'b0; mw_man = 1'b0; ctrl_auto = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lc", lc, 0);
        check("rst_fir", fir_coefficient, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_err", err, 0);
        check("rst_overrun", wr_overrun, 0);
        check("rst_dr_out", data_ready_out, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Basic load: four coefficients through the handshake
        wr(2'd0, 16'h0001); wr(2'd1, 16'h0002); wr(2'd2, 16'h0003); wr(2'd3, 16'h0004);
        ctrl_auto = 1'b1; gb = got.size(); base_lc = lc_pulses; base_done = done_cnt;
        pulse_load();
        check("t1_lc_at_t1", lc, 0);
        check("t1_busy_at_t1", busy, 0);
        @(negedge clk);
        check("t1_lc_at_t2", lc, 1);
        check("t1_busy_at_t2", busy, 1);
        wait_done(base_done, 100, ok);
        check("t1_done_seen", ok, 1);
        @(negedge clk);
        check("t1_done_one_cycle", load_done, 0);
        check("t1_nvals", got.size() - gb, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_coeff%0d", i), got[gb + i], exp1[i]);
        check("t1_lc_pulses", lc_pulses - base_lc, 4);
        check("t1_done_count", done_cnt - base_done, 1);
        check("t1_busy_after", busy, 0);
        check("t1_fir_stable", fir_unstable, 0);
        ctrl_auto = 1'b0;

        // Load deferred behind an in-flight sample, then runs with data_ready gated
        data_ready_in = 1'b1; mw_man = 1'b1;
        base_lc = lc_pulses; base_done = done_cnt;
        pulse_load();
        repeat (4) @(negedge clk);
        check("t2_lc_deferred", lc_pulses - base_lc, 0);
        check("t2_busy_deferred", busy, 0);
        check("t2_dr_pass_idle", data_ready_out, 1);
        data_ready_in = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_lc_mw_only", lc_pulses - base_lc, 0);
        mw_man = 1'b0; ctrl_auto = 1'b1;
        @(negedge clk);
        check("t2_lc_after_quiet", lc, 1);
        data_ready_in = 1'b1;
        @(negedge clk);
        check("t2_dr_gated", data_ready_out, 0);
        wait_done(base_done, 100, ok);
        check("t2_done_seen", ok, 1);
        data_ready_in = 1'b0;
        @(negedge clk);
        check("t2_dr_viol", dr_viol, 0);
        check("t2_lc_pulses", lc_pulses - base_lc, 4);
        check("t2_done_count", done_cnt - base_done, 1);
        ctrl_auto = 1'b0;

        // Controller never answers: timeout to ERR, then recovery
        pulse_load();
        hi = 0;
        for (int i = 0; i < TO + 1; i++) begin
            @(negedge clk);
            if (lc === 1'b1 && err === 1'b0 && busy === 1'b1) hi++;
        end
        check("t3_lc_cycles", hi, TO + 1);
        @(negedge clk);
        check("t3_lc_dropped", lc, 0);
        check("t3_err_set", err, 1);
        check("t3_busy_in_err", busy, 0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", err, 1);
        ctrl_auto = 1'b1; base_done = done_cnt;
        pulse_load();
        check("t3_err_cleared", err, 0);
        wait_done(base_done, 100, ok);
        check("t3_done_seen", ok, 1);
        @(negedge clk);
        check("t3_err_after", err, 0);
        ctrl_auto = 1'b0;

        // Write accepted in IDLE, dropped during WAIT_ACK
        wr(2'd3, 16'h00A5);
        check("t4_idle_wr_no_overrun", wr_overrun, 0);
        base_lc = lc_pulses; base_done = done_cnt;
        pulse_load();
        wait_lc(base_lc + 1, 20, ok);
        check("t4_lc_seen", ok, 1);
        mw_man = 1'b1;
        @(negedge clk);
        check("t4_lc_low_wait_ack", lc, 0);
        coeff_wr = 1'b1; coeff_wr_idx = 2'd1; coeff_wr_data = 16'hBEEF;
        @(negedge clk);
        coeff_wr = 1'b0;
        check("t4_overrun_pulse", wr_overrun, 1);
        @(negedge clk);
        check("t4_overrun_1cyc", wr_overrun, 0);
        mw_man = 1'b0; ctrl_auto = 1'b1;
        wait_done(base_done, 100, ok);
        check("t4_done_seen", ok, 1);
        @(negedge clk);
        gb = got.size(); base_done = done_cnt;
        pulse_load();
        wait_done(base_done, 100, ok);
        check("t4_reload_done", ok, 1);
        @(negedge clk);
        check("t4_nvals", got.size() - gb, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_coeff%0d", i), got[gb + i], exp4[i]);

        // Repeated load_start while busy is ignored
        base_lc = lc_pulses; base_done = done_cnt;
        pulse_load();
        repeat (2) @(negedge clk);
        pulse_load();
        repeat (3) @(negedge clk);
        pulse_load();
        wait_done(base_done, 100, ok);
        check("t5_done_seen", ok, 1);
        repeat (20) @(negedge clk);
        check("t5_done_count", done_cnt - base_done, 1);
        check("t5_lc_pulses", lc_pulses - base_lc, 4);
        check("t5_busy_after", busy, 0);

        // Asynchronous reset in the middle of a load, at idx 2
        base_lc = lc_pulses; base_done = done_cnt;
        pulse_load();
        wait_lc(base_lc + 3, 60, ok);
        check("t6_third_lc", ok, 1);
        check("t6_fir_idx2", fir_coefficient, 16'h0003);
        ctrl_auto = 1'b0; mw_man = 1'b0;
        n_rst = 1'b0;
        #1;
        check("t6_rst_lc", lc, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_fir", fir_coefficient, 0);
        check("t6_rst_done", load_done, 0);
        check("t6_rst_err", err, 0);
        check("t6_rst_overrun", wr_overrun, 0);
        check("t6_rst_dr_out", data_ready_out, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_done", done_cnt - base_done, 0);
        check("t6_no_more_lc", lc_pulses - base_lc, 3);
        ctrl_auto = 1'b1; gb = got.size(); base_done = done_cnt;
        pulse_load();
        wait_done(base_done, 100, ok);
        check("t6_reload_done", ok, 1);
        @(negedge clk);
        check("t6_nvals", got.size() - gb, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_buf_cleared%0d", i), got[gb + i], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
